// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-way round-robin arbiter and mux sequencer with registered data output
// Optional feature macro: ARB_HOLD_LIMIT_EN (caps consecutive grant cycles at MAX_HOLD under contention)
module rr_arbiter_8 #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        req,
   input  logic [DATA_W-1:0] in0,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   input  logic [DATA_W-1:0] in3,
   input  logic [DATA_W-1:0] in4,
   input  logic [DATA_W-1:0] in5,
   input  logic [DATA_W-1:0] in6,
   input  logic [DATA_W-1:0] in7,
   output logic [7:0]        gnt,
   output logic [2:0]        sel,
   output logic [DATA_W-1:0] out,
   output logic              out_valid
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [2:0]        r_ptr;
   logic [2:0]        w_ptr_nxt;
   logic [7:0]        r_gnt;
   logic [7:0]        w_gnt_nxt;
   logic [2:0]        r_sel;
   logic [2:0]        w_sel_nxt;
   logic [DATA_W-1:0] r_out;
   logic              r_out_valid;

   logic [7:0]        w_others;
   logic [2:0]        w_pick_req;
   logic [2:0]        w_pick_oth;
   logic              w_take;
   logic [DATA_W-1:0] w_in [8];

`ifdef ARB_HOLD_LIMIT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   logic [7:0]        r_hold;
   logic [7:0]        w_hold_nxt;
`endif

   // First set bit of mask scanning ptr, ptr+1, ... with wrap; the lowest
   // offset wins, so iterate from the far end and let nearer hits overwrite.
   function automatic logic [2:0] f_pick(input logic [7:0] mask, input logic [2:0] ptr);
      logic [2:0] idx;
      logic [2:0] k3;
      idx = ptr;
      for (int k = 7; k >= 0; k--) begin
         k3 = ptr + 3'(k);
         if (mask[k3]) idx = k3;
      end
      return idx;
   endfunction

   assign w_in[0] = in0;
   assign w_in[1] = in1;
   assign w_in[2] = in2;
   assign w_in[3] = in3;
   assign w_in[4] = in4;
   assign w_in[5] = in5;
   assign w_in[6] = in6;
   assign w_in[7] = in7;

   // Requests other than the current owner's; ptr already sits past the
   // owner, so the owner is naturally last in any re-grant scan.
   assign w_others   = req & ~(8'd1 << r_sel);
   assign w_pick_req = f_pick(req, r_ptr);
   assign w_pick_oth = f_pick(w_others, r_ptr);
   assign w_take     = (r_state == S_GRANT) && req[r_sel];

   // Arbitration state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_ptr   <= 3'd0;
         r_gnt   <= 8'd0;
         r_sel   <= 3'd0;
`ifdef ARB_HOLD_LIMIT_EN
         r_hold  <= 8'd0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_gnt   <= w_gnt_nxt;
         r_sel   <= w_sel_nxt;
`ifdef ARB_HOLD_LIMIT_EN
         r_hold  <= w_hold_nxt;
`endif
      end
   end

   // Next grant, pointer and state; a handoff happens in one edge with no idle gap
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_gnt_nxt   = r_gnt;
      w_sel_nxt   = r_sel;
`ifdef ARB_HOLD_LIMIT_EN
      w_hold_nxt  = r_hold;
`endif
      case (r_state)
         S_IDLE: begin
            if (|req) begin
               w_state_nxt = S_GRANT;
               w_gnt_nxt   = 8'd1 << w_pick_req;
               w_sel_nxt   = w_pick_req;
               w_ptr_nxt   = w_pick_req + 3'd1;
`ifdef ARB_HOLD_LIMIT_EN
               w_hold_nxt  = 8'd0;
`endif
            end
         end
         S_GRANT: begin
            if (!req[r_sel]) begin
               if (|w_others) begin
                  w_gnt_nxt  = 8'd1 << w_pick_oth;
                  w_sel_nxt  = w_pick_oth;
                  w_ptr_nxt  = w_pick_oth + 3'd1;
               end else begin
                  // sel deliberately keeps its last value when going idle
                  w_state_nxt = S_IDLE;
                  w_gnt_nxt   = 8'd0;
               end
`ifdef ARB_HOLD_LIMIT_EN
               w_hold_nxt = 8'd0;
`endif
            end
`ifdef ARB_HOLD_LIMIT_EN
            else if (r_hold == HOLD_LAST) begin
               if (|w_others) begin
                  w_gnt_nxt  = 8'd1 << w_pick_oth;
                  w_sel_nxt  = w_pick_oth;
                  w_ptr_nxt  = w_pick_oth + 3'd1;
               end
               w_hold_nxt = 8'd0;
            end else begin
               w_hold_nxt = r_hold + 8'd1;
            end
`endif
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Capture the owner's word one cycle behind the grant while it still requests
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= w_take;
         if (w_take) r_out <= w_in[r_sel];
      end
   end

   assign gnt       = r_gnt;
   assign sel       = r_sel;
   assign out       = r_out;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - directed self-checking bench for rr_arbiter_8
module tb_rr_arbiter_8;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] in0, in1, in2, in3, in4, in5, in6, in7;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic [7:0] out;
   logic       out_valid;

   int n_vec;
   int n_err;

   rr_arbiter_8 #(.DATA_W(8), .MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .in0       (in0),
      .in1       (in1),
      .in2       (in2),
      .in3       (in3),
      .in4       (in4),
      .in5       (in5),
      .in6       (in6),
      .in7       (in7),
      .gnt       (gnt),
      .sel       (sel),
      .out       (out),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] exp_g;
      logic [7:0] data [8];
      n_vec = 0;
      n_err = 0;
      for (int i = 0; i < 8; i++) data[i] = 8'h10 + 8'(i);
      rst_n = 1'b0;
      req   = 8'h00;
      in0 = data[0]; in1 = data[1]; in2 = data[2]; in3 = 8'hA5;
      in4 = data[4]; in5 = data[5]; in6 = data[6]; in7 = data[7];
      #12;
      chk("rst_gnt", gnt, 8'h00);
      chk("rst_sel", {5'd0, sel}, 8'h00);
      chk("rst_out", out, 8'h00);
      chk("rst_valid", {7'd0, out_valid}, 8'h00);
      rst_n = 1'b1;

      // single request, data latency, async reset mid-grant
      req = 8'h08;
      step();
      chk("single_gnt", gnt, 8'h08);
      chk("single_sel", {5'd0, sel}, 8'h03);
      chk("single_valid0", {7'd0, out_valid}, 8'h00);
      step();
      chk("single_out", out, 8'hA5);
      chk("single_valid1", {7'd0, out_valid}, 8'h01);
      rst_n = 1'b0;
      #2;
      chk("async_gnt", gnt, 8'h00);
      chk("async_sel", {5'd0, sel}, 8'h00);
      chk("async_out", out, 8'h00);
      chk("async_valid", {7'd0, out_valid}, 8'h00);
      req = 8'h00;
      in3 = data[3];
      rst_n = 1'b1;

      // all request; each owner releases two cycles after its grant
      req = 8'hFF;
      step();
      for (int k = 0; k < 9; k++) begin
         exp_g = 8'd1 << (k % 8);
         chk($sformatf("rr_gnt_%0d", k), gnt, exp_g);
         chk($sformatf("rr_sel_%0d", k), {5'd0, sel}, 8'(k % 8));
         step();
         chk($sformatf("rr_hold_%0d", k), gnt, exp_g);
         chk($sformatf("rr_out_%0d", k), out, data[k % 8]);
         chk($sformatf("rr_val_%0d", k), {7'd0, out_valid}, 8'h01);
         req = req & ~exp_g;
         step();
         req = 8'hFF;
         chk($sformatf("rr_nobubble_%0d", k), {7'd0, |gnt}, 8'h01);
         chk($sformatf("rr_relval_%0d", k), {7'd0, out_valid}, 8'h00);
      end

      // wrap-around 6 -> 7 -> 0
      req = 8'h00;
      do_reset();
      req = 8'h40;
      step();
      chk("wrap_g6", gnt, 8'h40);
      req = 8'hC1;
      step();
      chk("wrap_g6_hold", gnt, 8'h40);
      req = 8'h81;
      step();
      chk("wrap_g7", gnt, 8'h80);
      chk("wrap_s7", {5'd0, sel}, 8'h07);
      req = 8'h01;
      step();
      chk("wrap_g0", gnt, 8'h01);
      chk("wrap_s0", {5'd0, sel}, 8'h00);

      // sole owner releases to idle, then a fresh request
      req = 8'h00;
      do_reset();
      req = 8'h20;
      step();
      chk("idle_g5", gnt, 8'h20);
      step();
      chk("idle_out5", out, data[5]);
      req = 8'h00;
      step();
      chk("idle_gnt0", gnt, 8'h00);
      chk("idle_val0", {7'd0, out_valid}, 8'h00);
      chk("idle_selkeep", {5'd0, sel}, 8'h05);
      req = 8'h02;
      step();
      chk("idle_g1", gnt, 8'h02);
      chk("idle_s1", {5'd0, sel}, 8'h01);

      // two constant requesters: hold limit alternates, otherwise owner 0 keeps it
      req = 8'h00;
      do_reset();
      req = 8'h03;
      for (int c = 0; c < 16; c++) begin
         step();
`ifdef ARB_HOLD_LIMIT_EN
         exp_g = (((c / 4) % 2) == 1) ? 8'h02 : 8'h01;
`else
         exp_g = 8'h01;
`endif
         chk($sformatf("hold_gnt_%0d", c), gnt, exp_g);
         if (c >= 1) chk($sformatf("hold_val_%0d", c), {7'd0, out_valid}, 8'h01);
      end

      // lone owner for 20 cycles, out tracks in4
      req = 8'h00;
      do_reset();
      req = 8'h10;
      for (int c = 0; c < 20; c++) begin
         in4 = 8'h40 + 8'(c * 3);
         step();
         chk($sformatf("lone_gnt_%0d", c), gnt, 8'h10);
         if (c >= 1) begin
            chk($sformatf("lone_val_%0d", c), {7'd0, out_valid}, 8'h01);
            chk($sformatf("lone_out_%0d", c), out, 8'h40 + 8'(c * 3));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
